// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl: control FSM for a 3-register shift-and-add datapath.
// R0 = multiplicand, R1 = multiplier, R2 = accumulator.
// When the loop finishes, R2 = (a*b) mod 2^WIDTH.
// Optional build macro: SKIP_ZERO_ADD_EN. When it is defined, the ADD cycle is
// skipped for zero multiplier bits.
module shift_add_mul_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             lsb,
  output logic [WIDTH-1:0] dp_in,
  output logic             w,
  output logic [1:0]       Rd,
  output logic             sel,
  output logic [1:0]       Ri,
  output logic [1:0]       Rj,
  output logic [1:0]       aop,
  output logic             loadb,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LDA, S_LDB, S_CLR, S_CHK, S_SHB, S_ADD, S_SHA, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last_iter;

  // The counter reaches WIDTH only after the final SHA, so it never wraps.
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Iteration counter: cleared in CLR, advanced once per iteration in SHA
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (state == S_CLR)   cnt <= '0;
    else if (state == S_SHA)   cnt <= cnt + 1'b1;
  end

  // Next-state decode
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: state_nxt = start ? S_LDA : S_IDLE;
      S_LDA:  state_nxt = S_LDB;
      S_LDB:  state_nxt = S_CLR;
      S_CLR:  state_nxt = S_CHK;
      S_CHK:  state_nxt = S_SHB;
`ifdef SKIP_ZERO_ADD_EN
      S_SHB:  state_nxt = lsb ? S_ADD : S_SHA;
`else
      S_SHB:  state_nxt = S_ADD;
`endif
      S_ADD:  state_nxt = S_SHA;
      S_SHA:  state_nxt = last_iter ? S_DONE : S_CHK;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: Moore on state, except w in ADD, which follows the captured bit
  always_comb begin
    dp_in = '0;
    w     = 1'b0;
    Rd    = 2'b00;
    sel   = 1'b0;
    Ri    = 2'b00;
    Rj    = 2'b00;
    aop   = 2'b00;
    loadb = 1'b0;
    busy  = (state != S_IDLE);
    done  = 1'b0;
    case (state)
      S_LDA: begin w = 1'b1; Rd = 2'b00; sel = 1'b1; dp_in = a; end
      S_LDB: begin w = 1'b1; Rd = 2'b01; sel = 1'b1; dp_in = b; end
      S_CLR: begin w = 1'b1; Rd = 2'b10; sel = 1'b1; end
      // Pass R1 through the ALU so that the lsb register captures R1[0]
      S_CHK: begin aop = 2'b11; Ri = 2'b01; loadb = 1'b1; end
      S_SHB: begin w = 1'b1; Rd = 2'b01; aop = 2'b00; Ri = 2'b01; end
      S_ADD: begin w = lsb; Rd = 2'b10; aop = 2'b10; Ri = 2'b10; Rj = 2'b00; end
      S_SHA: begin w = 1'b1; Rd = 2'b00; aop = 2'b01; Ri = 2'b00; end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Bench for shift_add_mul_ctrl. A behavioural 3-register datapath closes the loop.
// Expected products and done cycles are queued when a start is accepted.
// They are checked when done pulses.
module tb_shift_add_mul_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         lsb;
  logic [W-1:0] dp_in;
  logic         w, sel, loadb, busy, done;
  logic [1:0]   Rd, Ri, Rj, aop;

  shift_add_mul_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .lsb(lsb),
    .dp_in(dp_in), .w(w), .Rd(Rd), .sel(sel), .Ri(Ri), .Rj(Rj), .aop(aop),
    .loadb(loadb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: registers R0..R2, an ALU and the lsb register
  logic [W-1:0] r [3];
  logic         lsb_q = 1'b0;
  initial begin r[0] = '0; r[1] = '0; r[2] = '0; end
  assign lsb = lsb_q;

  function automatic logic [W-1:0] alu(input logic [1:0] op, input logic [W-1:0] i, input logic [W-1:0] j);
    case (op)
      2'b00:   alu = i >> 1;
      2'b01:   alu = i << 1;
      2'b10:   alu = i + j;
      default: alu = i;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] res;
    res = alu(aop, r[Ri], r[Rj]);
    if (w && Rd != 2'b11) r[Rd] <= sel ? dp_in : res;
    if (loadb) lsb_q <= res[0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int done_cnt = 0, add_w_cnt = 0;

  typedef struct { logic [W-1:0] prod; int exp_cyc; } exp_t;
  exp_t sb [$];

  function automatic int lat(input logic [W-1:0] bb);
`ifdef SKIP_ZERO_ADD_EN
    lat = 4 + 3 * W + $countones(bb);
`else
    lat = 4 * W + 4;
`endif
  endfunction

  // Scoreboard monitor: check the product and done timing, and count writes in ADD
  always @(negedge clk) begin
    if (!reset && Rd == 2'b10 && aop == 2'b10 && w) add_w_cnt++;
    if (!reset && done) begin
      exp_t e;
      done_cnt++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done cyc=%0d (no operation pending)", cyc);
      end else begin
        e = sb.pop_front();
        if (r[2] !== e.prod) begin
          bad++;
          $display("FAIL product got=%h exp=%h", r[2], e.prod);
        end
        total++;
        if (cyc !== e.exp_cyc) begin
          bad++;
          $display("FAIL done_cycle got=%0d exp=%0d", cyc, e.exp_cyc);
        end
      end
    end
  end

  // Start one operation from IDLE; k is the cycle count just after the accepting edge
  task automatic start_op(input logic [W-1:0] aa, input logic [W-1:0] bb, output int k);
    exp_t e;
    @(negedge clk);
    start = 1'b1; a = aa; b = bb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    e.prod = aa * bb;
    e.exp_cyc = k + lat(bb) - 1;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({dp_in, w, Rd, sel, Ri, Rj, aop, loadb, busy, done} !== 29'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {dp_in, w, Rd, sel, Ri, Rj, aop, loadb, busy, done});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int k, busy_n;
    start_op(16'd3, 16'd5, k);
    busy_n = 0;
    while (sb.size() != 0 && busy_n < 200) begin
      if (busy) busy_n++;
      @(negedge clk);
    end
    total++;
    if (busy_n !== lat(16'd5)) begin
      bad++;
      $display("FAIL busy_cycles got=%0d exp=%0d", busy_n, lat(16'd5));
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_after_done got=%b exp=0", busy);
    end
  endtask

  task automatic test_wrap;
    int k;
    start_op(16'hFFFF, 16'hFFFF, k); wait_idle(200);
    start_op(16'h0100, 16'h0100, k); wait_idle(200);
    start_op(16'hA5C3, 16'h3E17, k); wait_idle(200);
  endtask

  task automatic test_zero;
    int k;
    add_w_cnt = 0;
    start_op(16'h1234, 16'h0000, k); wait_idle(200);
    total++;
    if (add_w_cnt !== 0) begin
      bad++;
      $display("FAIL add_write_b0 got=%0d exp=0", add_w_cnt);
    end
    start_op(16'h0000, 16'hBEEF, k); wait_idle(200);
    add_w_cnt = 0;
    start_op(16'h0001, 16'h8421, k); wait_idle(200);
    total++;
    if (add_w_cnt !== 4) begin
      bad++;
      $display("FAIL add_write_count got=%0d exp=4", add_w_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int k, shb, n, d0;
    start_op(16'h1111, 16'h00FF, k);
    shb = 0; n = 0;
    while (shb < 7 && n < 200) begin
      if (w && Rd == 2'b01 && !sel && aop == 2'b00) shb++;
      if (shb < 7) @(negedge clk);
      n++;
    end
    reset = 1'b1;
    #1;
    total++;
    if ({dp_in, w, Rd, sel, Ri, Rj, aop, loadb, busy, done} !== 29'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h exp=0", {dp_in, w, Rd, sel, Ri, Rj, aop, loadb, busy, done});
    end
    sb.delete();
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    total++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_no_done dones=%0d exp=%0d busy=%b", done_cnt - d0, 0, busy);
    end
    start_op(16'd7, 16'd6, k); wait_idle(200);
  endtask

  task automatic test_back_to_back;
    int k;
    exp_t e;
    start_op(16'h0003, 16'hFFFF, k);
    for (int n = 1; n <= 69; n++) begin
      start = (n == 10 || n == 68 || n == 69);
      if (n == 69) begin
        a = 16'h0011; b = 16'h0013;
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL idle_after_done got=%b exp=0", busy);
        end
        e.prod = 16'h0011 * 16'h0013;
        e.exp_cyc = k + 69 + lat(16'h0013) - 1;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle(300);
  endtask

  task automatic test_random;
    int k;
    for (int i = 0; i < 6; i++) begin
      start_op(W'($urandom), W'($urandom), k);
      wait_idle(200);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_zero;
    test_reset_mid;
    test_back_to_back;
    test_random;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
